// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - state and grant encodings shared by the memory port arbiter
package core_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory port between fetch and data requesters
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    grant_t     last_grant, owner, pick;
    logic       issue;
    logic       if_elig, d_elig;

    assign if_valid = (state == DONE) && (owner == GNT_IF);
    assign d_valid  = (state == DONE) && (owner == GNT_D);
    assign stall    = ~rst & ((if_req & ~if_valid) | (d_req & ~d_valid));

    // A requester's req is ignored in the cycle its own valid pulses.
    assign if_elig = if_req & ~if_valid;
    assign d_elig  = d_req & ~d_valid;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pick      = last_grant;
        issue     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        if (if_elig && d_elig) begin
            pick = (last_grant == GNT_IF) ? GNT_D : GNT_IF;
        end else if (d_elig) begin
            pick = GNT_D;
        end else begin
            pick = GNT_IF;
        end

        case (state)
            IDLE: begin
                if (!rst && (if_elig || d_elig)) begin
                    issue     = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = (pick == GNT_D) && d_we;
                    mem_addr  = (pick == GNT_D) ? d_addr : if_addr;
                    mem_wdata = d_wdata;
                    if ((pick == GNT_D) && d_we) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RD_WAIT;
                        cnt_nxt   = LAT_INIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= GNT_IF;
            owner      <= GNT_IF;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (issue) begin
                last_grant <= pick;
                owner      <= pick;
            end
            // Read data is valid on the last RD_WAIT cycle; hold it until the next capture.
            if ((state == RD_WAIT) && (cnt == 4'd0)) begin
                if (owner == GNT_IF) begin
                    if_rdata <= mem_rdata;
                end else begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        stall;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [7:0] idx);
        return (idx == 8'd4) ? 32'h00500093 : {idx, ~idx, 8'h5A, idx};
    endfunction

    // Synchronous memory with LAT-cycle read latency.
    logic [31:0] mem_arr [0:255];
    bit          mem_wr  [0:255];
    logic [31:0] pipe    [0:LAT-1];
    assign mem_rdata = pipe[LAT-1];

    always @(posedge clk) begin
        pipe[0] <= (mem_en && !mem_we) ?
                   (mem_wr[mem_addr[9:2]] ? mem_arr[mem_addr[9:2]] : init_val(mem_addr[9:2])) : 32'h0;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        if (mem_en && mem_we) begin
            mem_arr[mem_addr[9:2]] <= mem_wdata;
            mem_wr[mem_addr[9:2]]  <= 1'b1;
        end
    end

    // Reference model: one transaction at a time, round-robin on contention.
    logic [31:0] ref_mem [0:255];
    bit          ref_wr  [0:255];
    bit          busy = 0;
    bit          win = 0;
    bit          tx_we = 0;
    bit          last_model = 0;
    bit          exp_win;
    logic [31:0] tx_addr, tx_data;
    int          busy_cyc = 0;
    int          log_n = 0;
    int          if_cnt = 0;
    int          d_cnt = 0;
    bit          grant_log [0:255];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_wr[a[9:2]] ? ref_mem[a[9:2]] : init_val(a[9:2]);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            busy = 0;
            last_model = 0;
        end else begin
            check("stall", 32'(stall), 32'((if_req && !if_valid) || (d_req && !d_valid)));
            if (busy) busy_cyc++;
            if (mem_en) begin
                exp_win = (if_req && d_req) ? !last_model : d_req;
                check("mem_overlap", 32'(busy), 32'(0));
                check("mem_addr", mem_addr, exp_win ? d_addr : if_addr);
                check("mem_we", 32'(mem_we), 32'(exp_win && d_we));
                if (exp_win && d_we) check("mem_wdata", mem_wdata, d_wdata);
                busy = 1;
                busy_cyc = 0;
                win = exp_win;
                tx_we = exp_win && d_we;
                tx_addr = exp_win ? d_addr : if_addr;
                tx_data = d_wdata;
                last_model = exp_win;
                grant_log[log_n % 256] = exp_win;
                log_n++;
            end else begin
                check("mem_quiet", 32'(mem_we) | mem_addr | mem_wdata, 32'h0);
            end
            if (if_valid || d_valid) begin
                check("valid_owner", 32'({if_valid, d_valid}), busy ? (win ? 32'd1 : 32'd2) : 32'd0);
                if (busy) begin
                    check("latency", 32'(busy_cyc), tx_we ? 32'd1 : 32'(LAT + 1));
                    if (tx_we) begin
                        ref_mem[tx_addr[9:2]] = tx_data;
                        ref_wr[tx_addr[9:2]] = 1;
                    end else if (win) begin
                        check("d_rdata", d_rdata, ref_rd(tx_addr));
                    end else begin
                        check("if_rdata", if_rdata, ref_rd(tx_addr));
                    end
                    if (win) d_cnt++; else if_cnt++;
                    busy = 0;
                end
            end else if (busy && busy_cyc > 40) begin
                check("tx_timeout", 32'(busy_cyc), 32'(0));
                busy = 0;
            end
        end
    end

    task automatic do_reset();
        if_req = 0;
        d_req = 0;
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    // which: 0 = fetch valid, 1 = data valid, 2 = either.
    task automatic wait_valid(input int which, input string tag);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if ((which == 0 && if_valid) || (which == 1 && d_valid) ||
                (which == 2 && (if_valid || d_valid))) seen = 1;
        end
        if (!seen) check(tag, 32'(0), 32'(1));
    endtask

    task automatic if_requester(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            if_addr = {22'h0, 4'($urandom_range(0, 15)), 2'b00} | 32'h0;
            if_req = 1;
            wait_valid(0, "rand_if_timeout");
            @(posedge clk); #1;
            if_req = 0;
        end
    endtask

    task automatic d_requester(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            d_addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            d_we    = 1'($urandom_range(0, 1));
            d_wdata = $urandom;
            d_req = 1;
            wait_valid(1, "rand_d_timeout");
            @(posedge clk); #1;
            d_req = 0;
        end
    endtask

    int t0, t1, l0, ic0, dc0;

    initial begin
        do_reset();
        @(negedge clk);
        check("reset_ctl", 32'({if_valid, d_valid, stall, mem_en, mem_we}), 32'h0);
        check("reset_if_rdata", if_rdata, 32'h0);
        check("reset_d_rdata", d_rdata, 32'h0);

        // Lone fetch of 0x10.
        @(posedge clk); #1;
        if_addr = 32'h10;
        if_req = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("fetch_mem_en", 32'(mem_en), 32'(c == 0));
            check("fetch_stall", 32'(stall), 32'(c < 3));
            check("fetch_valid", 32'(if_valid), 32'(c == 3));
            if (c == 3) check("fetch_rdata", if_rdata, 32'h00500093);
        end
        @(posedge clk); #1;
        if_req = 0;

        // Lone store, then a load of the same address.
        d_we = 1;
        d_addr = 32'h40;
        d_wdata = 32'hDEADBEEF;
        d_req = 1;
        @(negedge clk);
        check("store_issue", 32'({mem_en, mem_we}), 32'h3);
        check("store_addr", mem_addr, 32'h40);
        check("store_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        check("store_valid", 32'({d_valid, mem_en}), 32'h2);
        @(posedge clk); #1;
        d_we = 0;
        wait_valid(1, "load_timeout");
        check("load_back", d_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        d_req = 0;

        // Reset in the middle of RD_WAIT abandons the fetch.
        if_addr = 32'h20;
        if_req = 1;
        @(posedge clk); #1;
        #2 rst = 1;
        #1;
        check("rst_ctl", 32'({if_valid, d_valid, stall, mem_en, mem_we}), 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_mem_bus", mem_addr | mem_wdata, 32'h0);
        if_req = 0;
        @(posedge clk); #1;
        rst = 0;
        ic0 = if_cnt;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("abandoned_valid", 32'(if_valid), 32'(0));
        end

        // Simultaneous requests after reset: D first, IF right after d_valid.
        do_reset();
        l0 = log_n; ic0 = if_cnt; dc0 = d_cnt;
        if_addr = 32'h8;
        d_addr = 32'h40;
        d_we = 0;
        if_req = 1;
        d_req = 1;
        wait_valid(1, "sim_d_timeout");
        @(posedge clk); #1;
        d_req = 0;
        @(negedge clk);
        check("sim_if_issue", 32'(mem_en), 32'(1));
        check("sim_if_addr", mem_addr, 32'h8);
        wait_valid(0, "sim_if_timeout");
        @(posedge clk); #1;
        if_req = 0;
        repeat (3) @(posedge clk); #1;
        check("sim_first_d", 32'(grant_log[l0 % 256]), 32'(1));
        check("sim_second_if", 32'(grant_log[(l0 + 1) % 256]), 32'(0));
        check("sim_if_once", 32'(if_cnt - ic0), 32'(1));
        check("sim_d_once", 32'(d_cnt - dc0), 32'(1));

        // Back-to-back fetches with if_req held.
        if_req = 1;
        t0 = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if_addr = 32'(k * 4);
            @(negedge clk);
            check("b2b_issue", 32'(mem_en), 32'(1));
            if (k == 0) t0 = cyc;
            wait_valid(0, "b2b_timeout");
        end
        t1 = cyc;
        check("b2b_cycles", 32'(t1 - t0 + 1), 32'(4 * (LAT + 2)));
        @(posedge clk); #1;
        if_req = 0;

        // Alternating contention for six transactions.
        do_reset();
        l0 = log_n; ic0 = if_cnt; dc0 = d_cnt;
        d_we = 0;
        if_req = 1;
        d_req = 1;
        for (int t = 0; t < 6; t++) begin
            wait_valid(2, "alt_timeout");
            @(posedge clk); #1;
            if_addr = 32'($urandom_range(0, 15) * 4);
            d_addr  = 32'($urandom_range(0, 15) * 4);
        end
        if_req = 0;
        d_req = 0;
        repeat (2) @(posedge clk); #1;
        for (int t = 0; t < 6; t++)
            check("alt_order", 32'(grant_log[(l0 + t) % 256]), 32'(t % 2 == 0));
        check("alt_counts", 32'((if_cnt - ic0) * 16 + (d_cnt - dc0)), 32'(3 * 16 + 3));

        // Randomized concurrent traffic against the reference model.
        ic0 = if_cnt; dc0 = d_cnt;
        fork
            if_requester(15);
            d_requester(15);
        join
        repeat (5) @(posedge clk); #1;
        check("rand_tx_count", 32'((if_cnt - ic0) + (d_cnt - dc0)), 32'(30));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
